two_bit_divider: RTL

- Sequential restoring divider: the inverse operation of the team's 2x2 combinational multiplier.
- Takes a 4-bit product-range dividend and a 2-bit divisor, and returns quotient and remainder after one iteration per dividend bit.
- Used by lab benches to recover factors from multiplier outputs and cross-check them.
- Start/busy/done handshake; one result in flight at a time.

---
 rtl/two_bit_divider_if.sv | 40 ++++
 rtl/two_bit_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/two_bit_divider_if.sv
// Start/busy/done handshake bundle for two_bit_divider: the requester drives the
// start strobe and operands, the divider returns status and the result.
interface two_bit_divider_if #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  check_err;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero,
        input  check_err
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero,
        output check_err
    );
endinterface

// File: rtl/two_bit_divider.sv
// Sequential restoring divider, one quotient bit per clock (inverse of the 2x2 multiplier).
// Define DIV_CHECK_EN to build the quotient*divisor+remainder self-check driving check_err.
module two_bit_divider #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    two_bit_divider_if.slave   divIf
);

    localparam int CNT_W  = $clog2(DIVIDEND_W + 1);
    localparam int REM_W  = DIVISOR_W + 1;
    localparam int PROD_W = DIVIDEND_W + DIVISOR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [DIVIDEND_W-1:0] dividendSr_q, dividendSr_d;
    logic [DIVISOR_W-1:0]  divisor_q,    divisor_d;
    logic [REM_W-1:0]      partRem_q,    partRem_d;
    logic [DIVIDEND_W-1:0] quotSr_q,     quotSr_d;
    logic [CNT_W-1:0]      count_q,      count_d;
    logic [DIVIDEND_W-1:0] quotient_q,   quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q,  remainder_d;
    logic                  divByZero_q,  divByZero_d;

    logic [REM_W-1:0]      shiftRem;
    logic [REM_W-1:0]      stepRem;
    logic                  stepBit;
    logic [DIVIDEND_W-1:0] stepQuot;

`ifdef DIV_CHECK_EN
    logic [DIVIDEND_W-1:0] dividendCap_q, dividendCap_d;
    logic                  checkErr_q,    checkErr_d;
    logic [PROD_W-1:0]     recon;
`endif

    // The extra partial-remainder bit keeps the compare against the divisor from overflowing.
    always_comb begin
        shiftRem = {partRem_q[DIVISOR_W-1:0], dividendSr_q[DIVIDEND_W-1]};
        stepRem  = shiftRem;
        stepBit  = 1'b0;
        if (shiftRem >= {1'b0, divisor_q}) begin
            stepRem = shiftRem - {1'b0, divisor_q};
            stepBit = 1'b1;
        end
        stepQuot = DIVIDEND_W'({quotSr_q, stepBit});
    end

`ifdef DIV_CHECK_EN
    assign recon = PROD_W'(stepQuot) * PROD_W'(divisor_q)
                 + PROD_W'(stepRem[DIVISOR_W-1:0]);
`endif

    always_comb begin
        state_d      = state_q;
        dividendSr_d = dividendSr_q;
        divisor_d    = divisor_q;
        partRem_d    = partRem_q;
        quotSr_d     = quotSr_q;
        count_d      = count_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        divByZero_d  = divByZero_q;
`ifdef DIV_CHECK_EN
        dividendCap_d = dividendCap_q;
        checkErr_d    = 1'b0;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                // DONE accepts a new start exactly like IDLE, allowing back-to-back requests.
                if (divIf.start) begin
                    dividendSr_d = divIf.dividend;
                    divisor_d    = divIf.divisor;
                    partRem_d    = '0;
                    quotSr_d     = '0;
                    count_d      = CNT_W'(DIVIDEND_W);
                    divByZero_d  = 1'b0;
`ifdef DIV_CHECK_EN
                    dividendCap_d = divIf.dividend;
`endif
                    if (divIf.divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        divByZero_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                partRem_d    = stepRem;
                dividendSr_d = dividendSr_q << 1;
                quotSr_d     = stepQuot;
                count_d      = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    quotient_d  = stepQuot;
                    remainder_d = stepRem[DIVISOR_W-1:0];
                    divByZero_d = 1'b0;
`ifdef DIV_CHECK_EN
                    checkErr_d  = (recon != PROD_W'(dividendCap_q));
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            dividendSr_q <= '0;
            divisor_q    <= '0;
            partRem_q    <= '0;
            quotSr_q     <= '0;
            count_q      <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            divByZero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dividendSr_q <= dividendSr_d;
            divisor_q    <= divisor_d;
            partRem_q    <= partRem_d;
            quotSr_q     <= quotSr_d;
            count_q      <= count_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            divByZero_q  <= divByZero_d;
        end
    end

`ifdef DIV_CHECK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dividendCap_q <= '0;
            checkErr_q    <= 1'b0;
        end else begin
            dividendCap_q <= dividendCap_d;
            checkErr_q    <= checkErr_d;
        end
    end

    assign divIf.check_err = checkErr_q;
`else
    assign divIf.check_err = 1'b0;
`endif

    assign divIf.busy        = (state_q == RUN);
    assign divIf.done        = (state_q == DONE);
    assign divIf.quotient    = quotient_q;
    assign divIf.remainder   = remainder_q;
    assign divIf.div_by_zero = divByZero_q;

endmodule
